// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_loader
// Purpose  : Boot loader. Receives a framed program image over UART
//            (A5 | addr[4] | count[4] | data[4*N] | csum) and writes it word
//            by word to a memory port. Holds the core in reset until a
//            checksum-verified image has been fully written, then locks out
//            until the next reset.
// Ports    : clk_i, rst_ni        clock, async active-low reset
//            uart_rx_i            UART line (async, idle high)
//            mem_req_o/mem_gnt_i  write handshake
//            mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  write command
//            core_rst_no          core reset (1 = released)
//            busy_o, err_o        frame in progress / sticky error
// Revision : 1.0  initial release
// ============================================================================
module uart_mem_loader #(
    parameter int unsigned CLK_DIV   = 434,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        uart_rx_i,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_rst_no,
    output logic        busy_o,
    output logic        err_o
);

    localparam int unsigned CW      = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] C_HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] C_BIT_M1  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [7:0]    C_SYNC    = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_SYNC, P_ADDR, P_LEN, P_DATA, P_CSUM, P_DONE} p_state_t;

    // RX front end
    logic            sync1_q, sync2_q, prev_q;
    rx_state_t       rx_st_q, rx_st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_vld_q, byte_vld_d;
    logic            frm_err_q, frm_err_d;

    // Parser and write buffer
    p_state_t        p_st_q, p_st_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [31:0]     acc_q, acc_d;
    logic [31:0]     wr_addr_q, wr_addr_d;
    logic [31:0]     words_q, words_d;
    logic [7:0]      sum_q, sum_d;
    logic            csum_wait_q, csum_wait_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            core_rst_n_q, core_rst_n_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic [31:0]     w_shifted;
    logic [31:0]     w_start_addr;
    logic            w_grant;
    logic            w_last_byte;

    // ---------------- RX bit engine ----------------
    always_comb begin
        rx_st_d    = rx_st_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_vld_d = 1'b0;
        frm_err_d  = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    rx_st_d = RX_START;
                    cnt_d   = C_HALF_M1;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    // Glitch filter: the line must still be low mid start bit
                    if (!sync2_q) begin
                        rx_st_d = RX_DATA;
                        cnt_d   = C_BIT_M1;
                        bit_d   = 3'd0;
                    end else begin
                        rx_st_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = C_BIT_M1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rx_st_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            default: begin // RX_STOP
                if (cnt_q == '0) begin
                    byte_vld_d = sync2_q;
                    frm_err_d  = !sync2_q;
                    rx_st_d    = RX_IDLE;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
        endcase
    end

    // ---------------- Frame parser ----------------
    // Multi-byte fields arrive LSB first, so shifting each byte in at the top
    // leaves the little-endian value in acc after four bytes.
    assign w_shifted    = {shift_q, acc_q[31:8]};
    assign w_start_addr = {w_shifted[31:2], 2'b00};
    assign w_grant      = req_q && mem_gnt_i;
    assign w_last_byte  = (bcnt_q == 2'd3);

    always_comb begin
        p_st_d       = p_st_q;
        bcnt_d       = bcnt_q;
        acc_d        = acc_q;
        wr_addr_d    = wr_addr_q;
        words_d      = words_q;
        sum_d        = sum_q;
        csum_wait_d  = csum_wait_q;
        req_d        = w_grant ? 1'b0 : req_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        core_rst_n_d = core_rst_n_q;
        busy_d       = busy_q;
        err_d        = err_q;

        if (frm_err_q && (p_st_q != P_DONE)) begin
            err_d       = 1'b1;
            busy_d      = 1'b0;
            csum_wait_d = 1'b0;
            p_st_d      = P_SYNC;
        end else begin
            case (p_st_q)
                P_SYNC: begin
                    if (byte_vld_q && (shift_q == C_SYNC)) begin
                        p_st_d = P_ADDR;
                        bcnt_d = 2'd0;
                        sum_d  = 8'd0;
                        err_d  = 1'b0;
                        busy_d = 1'b1;
                    end
                end
                P_ADDR: begin
                    if (byte_vld_q) begin
                        acc_d  = w_shifted;
                        bcnt_d = bcnt_q + 2'd1;
                        if (w_last_byte) begin
                            if (w_start_addr < BASE_ADDR) begin
                                err_d  = 1'b1;
                                busy_d = 1'b0;
                                p_st_d = P_SYNC;
                            end else begin
                                wr_addr_d = w_start_addr;
                                p_st_d    = P_LEN;
                            end
                        end
                    end
                end
                P_LEN: begin
                    if (byte_vld_q) begin
                        acc_d  = w_shifted;
                        bcnt_d = bcnt_q + 2'd1;
                        if (w_last_byte) begin
                            words_d = w_shifted;
                            p_st_d  = (w_shifted == 32'd0) ? P_CSUM : P_DATA;
                        end
                    end
                end
                P_DATA: begin
                    if (byte_vld_q) begin
                        acc_d  = w_shifted;
                        bcnt_d = bcnt_q + 2'd1;
                        sum_d  = sum_q + shift_q;
                        if (w_last_byte) begin
                            if (req_q && !mem_gnt_i) begin
                                // Previous word still unaccepted: overrun
                                req_d  = 1'b0;
                                err_d  = 1'b1;
                                busy_d = 1'b0;
                                p_st_d = P_SYNC;
                            end else begin
                                req_d     = 1'b1;
                                addr_d    = wr_addr_q;
                                wdata_d   = w_shifted;
                                wr_addr_d = wr_addr_q + 32'd4;
                                words_d   = words_q - 32'd1;
                                if (words_q == 32'd1) begin
                                    p_st_d = P_CSUM;
                                end
                            end
                        end
                    end
                end
                P_CSUM: begin
                    if (csum_wait_q) begin
                        // Checksum already matched; release once the last
                        // write has been accepted.
                        if (!req_q || mem_gnt_i) begin
                            csum_wait_d  = 1'b0;
                            core_rst_n_d = 1'b1;
                            busy_d       = 1'b0;
                            p_st_d       = P_DONE;
                        end
                    end else if (byte_vld_q) begin
                        if (shift_q != sum_q) begin
                            err_d  = 1'b1;
                            busy_d = 1'b0;
                            p_st_d = P_SYNC;
                        end else if (req_q && !mem_gnt_i) begin
                            csum_wait_d = 1'b1;
                        end else begin
                            core_rst_n_d = 1'b1;
                            busy_d       = 1'b0;
                            p_st_d       = P_DONE;
                        end
                    end
                end
                default: begin // P_DONE: loader locked out until reset
                end
            endcase
        end

        we_d = req_d;
        be_d = {4{req_d}};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            rx_st_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'd0;
            byte_vld_q   <= 1'b0;
            frm_err_q    <= 1'b0;
            p_st_q       <= P_SYNC;
            bcnt_q       <= 2'd0;
            acc_q        <= 32'd0;
            wr_addr_q    <= 32'd0;
            words_q      <= 32'd0;
            sum_q        <= 8'd0;
            csum_wait_q  <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= 4'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            sync1_q      <= uart_rx_i;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            rx_st_q      <= rx_st_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_vld_q   <= byte_vld_d;
            frm_err_q    <= frm_err_d;
            p_st_q       <= p_st_d;
            bcnt_q       <= bcnt_d;
            acc_q        <= acc_d;
            wr_addr_q    <= wr_addr_d;
            words_q      <= words_d;
            sum_q        <= sum_d;
            csum_wait_q  <= csum_wait_d;
            req_q        <= req_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign core_rst_no = core_rst_n_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mem_loader
// Purpose  : Self-checking bench for uart_mem_loader. Frames are serialised
//            onto the UART line; a memory monitor records granted writes and
//            a frame-level model predicts writes, checksum and status.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_mem_loader;

    localparam int unsigned CLK_DIV = 8;
    localparam logic [31:0] BASE    = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        gnt = 1'b1;
    logic        mem_req_o, mem_we_o, core_rst_no, busy_o, err_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] words [16];
    logic [31:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
    logic [3:0]  got_be[$];
    logic        got_we[$];
    bit          seen_req, seen_busy;

    uart_mem_loader #(.CLK_DIV(CLK_DIV), .BASE_ADDR(BASE)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .uart_rx_i  (rx),
        .mem_req_o  (mem_req_o),
        .mem_gnt_i  (gnt),
        .mem_we_o   (mem_we_o),
        .mem_be_o   (mem_be_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .core_rst_no(core_rst_no),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    // Memory-side monitor: a write is accepted when req and gnt are both high
    always @(negedge clk) begin
        if (mem_req_o) seen_req = 1'b1;
        if (busy_o) seen_busy = 1'b1;
        if (mem_req_o === 1'b1 && gnt === 1'b1) begin
            got_addr.push_back(mem_addr_o);
            got_data.push_back(mem_wdata_o);
            got_be.push_back(mem_be_o);
            got_we.push_back(mem_we_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_csum(input int n);
        logic [7:0] s = 8'd0;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 4; b++)
                s = s + words[i][8*b +: 8];
        return s;
    endfunction

    function automatic void model_writes(input logic [31:0] addr, input int n);
        logic [31:0] a = addr & 32'hFFFF_FFFC;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(a);
            exp_data.push_back(words[i]);
            a = a + 32'd4;
        end
    endfunction

    task automatic check_writes(input string tag);
        chk({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            chk({tag, "_addr"}, got_addr[i], exp_addr[i]);
            chk({tag, "_data"}, got_data[i], exp_data[i]);
            chk({tag, "_be"}, {28'd0, got_be[i]}, 32'hF);
            chk({tag, "_we"}, {31'd0, got_we[i]}, 32'd1);
        end
        got_addr.delete(); got_data.delete(); got_be.delete(); got_we.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (CLK_DIV) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(posedge clk); #1;
        end
        rx = stop_ok;
        repeat (CLK_DIV) @(posedge clk); #1;
        rx = 1'b1;
        repeat (CLK_DIV) @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
    endtask

    task automatic send_body(input logic [31:0] addr, input int n, input bit bad);
        send_word(addr);
        send_word(32'(n));
        for (int i = 0; i < n; i++) send_word(words[i]);
        send_byte(bad ? model_csum(n) + 8'd1 : model_csum(n));
    endtask

    task automatic send_frame(input logic [31:0] addr, input int n, input bit bad);
        send_byte(8'hA5);
        send_body(addr, n, bad);
    endtask

    task automatic randomize_words(input int n);
        for (int i = 0; i < n; i++) words[i] = $urandom;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        gnt   = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        got_addr.delete(); got_data.delete(); got_be.delete(); got_we.delete();
        exp_addr.delete(); exp_data.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, mem_req_o}, 32'd0);
        chk({tag, "_we"},    {31'd0, mem_we_o}, 32'd0);
        chk({tag, "_be"},    {28'd0, mem_be_o}, 32'd0);
        chk({tag, "_addr"},  mem_addr_o, 32'd0);
        chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
        chk({tag, "_core"},  {31'd0, core_rst_no}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
        chk({tag, "_err"},   {31'd0, err_o}, 32'd0);
    endtask

    task automatic check_status(input string tag, input bit exp_err, input bit exp_rel);
        chk({tag, "_err"},  {31'd0, err_o}, {31'd0, exp_err});
        chk({tag, "_core"}, {31'd0, core_rst_no}, {31'd0, exp_rel});
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] a;
        int          n;
        bit          bad;

        // Reset values
        #2;
        check_reset_outputs("rst");
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Happy path
        words[0] = 32'h1122_3344;
        words[1] = 32'hDEAD_BEEF;
        send_byte(8'hA5);
        send_body(32'h0000_1000, 2, 1'b0);
        model_writes(32'h0000_1000, 2);
        check_writes("happy");
        check_status("happy", 1'b0, 1'b1);

        // Bad checksum, then the correct frame
        do_reset();
        send_frame(32'h0000_1000, 2, 1'b1);
        model_writes(32'h0000_1000, 2);
        check_writes("badcs");
        check_status("badcs", 1'b1, 1'b0);
        send_byte(8'hA5);
        chk("resync_err", {31'd0, err_o}, 32'd0);
        chk("resync_busy", {31'd0, busy_o}, 32'd1);
        send_body(32'h0000_1000, 2, 1'b0);
        model_writes(32'h0000_1000, 2);
        check_writes("resend");
        check_status("resend", 1'b0, 1'b1);

        // Stray bytes, framing error in LEN, then good frame after strays
        do_reset();
        send_byte(8'h00);
        send_byte(8'h5A);
        chk("stray_busy", {31'd0, busy_o}, 32'd0);
        send_byte(8'hA5);
        send_word(32'h0000_2000);
        send_byte(8'h02, 1'b0);
        check_writes("framing");
        check_status("framing", 1'b1, 1'b0);
        randomize_words(1);
        send_byte(8'h00);
        send_byte(8'h5A);
        send_frame(32'h0000_2000, 1, 1'b0);
        model_writes(32'h0000_2000, 1);
        check_writes("after_strays");
        check_status("after_strays", 1'b0, 1'b1);

        // Grant stall on word 1, then grant
        do_reset();
        randomize_words(2);
        gnt = 1'b0;
        send_byte(8'hA5);
        send_word(32'h0000_3000);
        send_word(32'd2);
        send_word(words[0]);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_req",  {31'd0, mem_req_o}, 32'd1);
            chk("stall_addr", mem_addr_o, 32'h0000_3000);
            chk("stall_data", mem_wdata_o, words[0]);
        end
        @(posedge clk); #1;
        gnt = 1'b1;
        send_word(words[1]);
        send_byte(model_csum(2));
        model_writes(32'h0000_3000, 2);
        check_writes("stall");
        check_status("stall", 1'b0, 1'b1);

        // Overrun: grant held low through word 2
        do_reset();
        randomize_words(2);
        gnt = 1'b0;
        send_byte(8'hA5);
        send_word(32'h0000_3000);
        send_word(32'd2);
        send_word(words[0]);
        send_word(words[1]);
        chk("ovr_req", {31'd0, mem_req_o}, 32'd0);
        check_status("ovr", 1'b1, 1'b0);
        gnt = 1'b1;
        check_writes("ovr");

        // N = 0
        do_reset();
        send_frame(32'h0000_1000, 0, 1'b0);
        check_writes("n0");
        check_status("n0", 1'b0, 1'b1);

        // Start address below base
        do_reset();
        send_frame(32'h0000_0FFC, 0, 1'b0);
        check_writes("lowaddr");
        check_status("lowaddr", 1'b1, 1'b0);

        // Address wrap
        do_reset();
        randomize_words(2);
        send_frame(32'hFFFF_FFFC, 2, 1'b0);
        model_writes(32'hFFFF_FFFC, 2);
        check_writes("wrap");
        check_status("wrap", 1'b0, 1'b1);

        // Random frames (unaligned start addresses, random checksum corruption)
        for (int k = 0; k < 3; k++) begin
            do_reset();
            n   = int'($urandom_range(1, 4));
            a   = BASE + 32'($urandom_range(0, 32'hFFFF));
            bad = 1'($urandom_range(0, 1));
            randomize_words(n);
            send_frame(a, n, bad);
            model_writes(a, n);
            check_writes("rand");
            check_status("rand", bad, !bad);
        end

        // Asynchronous reset in the middle of DATA with a pending request
        do_reset();
        randomize_words(3);
        gnt = 1'b0;
        send_byte(8'hA5);
        send_word(32'h0000_4000);
        send_word(32'd3);
        send_word(words[0]);
        send_byte(words[1][7:0]);
        send_byte(words[1][15:8]);
        chk("mid_req", {31'd0, mem_req_o}, 32'd1);
        chk("mid_busy", {31'd0, busy_o}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        gnt = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        got_addr.delete(); got_data.delete(); got_be.delete(); got_we.delete();
        repeat (2) @(posedge clk);

        // Post-release lockout
        randomize_words(2);
        send_frame(32'h0000_5000, 2, 1'b0);
        model_writes(32'h0000_5000, 2);
        check_writes("pre_lock");
        check_status("pre_lock", 1'b0, 1'b1);
        seen_req  = 1'b0;
        seen_busy = 1'b0;
        randomize_words(2);
        send_frame(32'h0000_6000, 2, 1'b0);
        chk("lock_req", {31'd0, seen_req}, 32'd0);
        chk("lock_busy", {31'd0, seen_busy}, 32'd0);
        chk("lock_core", {31'd0, core_rst_no}, 32'd1);
        check_writes("lock");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
